// File: rtl/mem_dump_reader_pkg.sv
// Shared processor package: memory address/data widths and the dump reader FSM encoding.
package mem_dump_reader_pkg;

    localparam int MEM_AW = 9;
    localparam int MEM_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } dump_state_t;

    function automatic logic state_is_busy(input dump_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Streams a block of words out of a synchronous-read memory over a valid/ready port.
// All outputs come straight from flops, decoded from the next state.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_a,
    input  logic [AW:0]   count,
    output logic [AW-1:0] mem_a,
    output logic          mem_re,
    input  logic [DW-1:0] mem_q,
    output logic [DW-1:0] dump_d,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic          busy,
    output logic          done
);

    dump_state_t   state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [AW:0]   rem_reg, rem_next;
    logic [DW-1:0] dump_d_reg, dump_d_next;
    logic [AW-1:0] mem_a_reg;
    logic          mem_re_reg, dump_valid_reg, busy_reg, done_reg;

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        rem_next    = rem_reg;
        dump_d_next = dump_d_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_next  = base_a;
                        rem_next   = count;
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_READ: state_next = abort ? ST_FIN : ST_WAIT;
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_FIN;
                end else begin
                    dump_d_next = mem_q;
                    state_next  = ST_SEND;
                end
            end
            ST_SEND: begin
                // A handshake coinciding with abort still counts as delivered.
                if (dump_ready) begin
                    rem_next = rem_reg - 1'b1;
                    if (rem_next == '0 || abort) begin
                        state_next = ST_FIN;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = ST_READ;
                    end
                end else if (abort) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            rem_reg        <= '0;
            dump_d_reg     <= '0;
            mem_a_reg      <= '0;
            mem_re_reg     <= 1'b0;
            dump_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            rem_reg        <= rem_next;
            dump_d_reg     <= dump_d_next;
            mem_a_reg      <= addr_next;
            mem_re_reg     <= (state_next == ST_READ);
            dump_valid_reg <= (state_next == ST_SEND);
            busy_reg       <= state_is_busy(state_next);
            done_reg       <= (state_next == ST_FIN);
        end
    end

    assign mem_a      = mem_a_reg;
    assign mem_re     = mem_re_reg;
    assign dump_d     = dump_d_reg;
    assign dump_valid = dump_valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of dump scenarios with a data/address scoreboard,
// plus hand-written idle-abort and mid-dump reset sequences.
module tb_mem_dump_reader;
    import mem_dump_reader_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, abort, dump_ready;
    logic [AW-1:0] base_a;
    logic [AW:0]   count;
    logic [AW-1:0] mem_a;
    logic          mem_re;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] dump_d;
    logic          dump_valid, busy, done;

    logic [DW-1:0] tb_mem [512];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];

    typedef struct {
        int base;
        int cnt;
        int stall;       // cycles dump_ready is held low in the first SEND
        int abort_rd;    // abort in the WAIT after this read number (0 = none)
        int restart_at;  // cycle a stray start is driven while busy (0 = none)
        int exp_words;
        int exp_reads;
        int exp_done;    // done cycle relative to the start cycle
    } vec_t;

    vec_t vecs[7];

    mem_dump_reader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_a(base_a), .count(count), .mem_a(mem_a), .mem_re(mem_re),
        .mem_q(mem_q), .dump_d(dump_d), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_q <= tb_mem[mem_a];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic run_dump(input vec_t v);
        int words = 0;
        int reads = 0;
        int stall_left = v.stall;
        logic prev_re = 1'b0;
        logic got_done = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        for (int j = 0; j < v.exp_words; j++) exp_data.push_back(tb_mem[(v.base + j) % 512]);
        for (int j = 0; j < v.exp_reads; j++) exp_addr.push_back(AW'((v.base + j) % 512));
        @(negedge clk);
        start  = 1'b1;
        base_a = AW'(v.base);
        count  = (AW+1)'(v.cnt);
        abort  = 1'b0;
        dump_ready = 1'b1;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start = (c == v.restart_at);
            if (start) begin
                base_a = 9'd300;
                count  = 10'd5;
            end
            abort = prev_re && (v.abort_rd != 0) && (reads == v.abort_rd);
            if (dump_valid && stall_left > 0) begin
                dump_ready = 1'b0;
                stall_left--;
                if (exp_data.size() > 0) chk("stall_dump_d", dump_d, exp_data[0]);
            end else begin
                if (stall_left < v.stall && stall_left > 0) chk("stall_valid", dump_valid, 1);
                dump_ready = 1'b1;
            end
            if (dump_valid && dump_ready) begin
                chk("hs_cycle", c, 3 + 3 * words + v.stall);
                if (exp_data.size() > 0) chk("dump_d", dump_d, exp_data.pop_front());
                else chk("extra_word", 1, 0);
                words++;
            end
            if (mem_re) begin
                if (exp_addr.size() > 0) chk("mem_a", mem_a, exp_addr.pop_front());
                else chk("extra_mem_re", 1, 0);
                reads++;
            end
            prev_re = mem_re;
            if (done) begin
                chk("done_cycle", c, v.exp_done);
                chk("valid_at_done", dump_valid, 0);
                chk("busy_at_done", busy, 1);
                got_done = 1'b1;
                break;
            end
        end
        chk("done_seen", got_done, 1);
        abort = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after", busy, 0);
        chk("mem_re_after", mem_re, 0);
        chk("words", words, v.exp_words);
        chk("reads", reads, v.exp_reads);
        chk("data_left", exp_data.size(), 0);
        $display("dump base=%0d count=%0d stall=%0d abort_rd=%0d: words=%0d reads=%0d",
                 v.base, v.cnt, v.stall, v.abort_rd, words, reads);
    endtask

    initial begin
        vec_t r;
        int valid_seen;
        for (int i = 0; i < 512; i++) tb_mem[i] = 32'hA000_0000 | i;
        for (int i = 0; i < 6; i++) tb_mem[i] = 32'h1111_1111 * (i + 1);

        //            base cnt stall abort restart words reads done
        vecs[0] = '{  0,   6,  0,    0,    0,      6,    6,    19};
        vecs[1] = '{510,   4,  0,    0,    0,      4,    4,    13};
        vecs[2] = '{ 20,   2,  5,    0,    0,      2,    2,    12};
        vecs[3] = '{  7,   0,  0,    0,    0,      0,    0,    1};
        vecs[4] = '{  0,   6,  0,    2,    0,      1,    2,    6};
        vecs[5] = '{100,   3,  0,    0,    2,      3,    3,    10};
        vecs[6] = '{200,   3,  0,    1,    0,      0,    1,    3};

        rst = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b1;
        base_a = '0; count = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_dump_d", dump_d, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // abort while idle must do nothing
        abort = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_abort_busy", busy, 0);
            chk("idle_abort_done", done, 0);
        end
        abort = 1'b0;

        for (int i = 0; i < 7; i++) run_dump(vecs[i]);

        // reset during the third SEND abandons the dump without done
        @(negedge clk);
        start = 1'b1; base_a = 9'd0; count = 10'd6; dump_ready = 1'b1;
        valid_seen = 0;
        for (int c = 0; c < 100 && valid_seen < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (dump_valid) valid_seen++;
        end
        chk("third_send_reached", valid_seen, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_mem_a", mem_a, 0);
        chk("mid_rst_mem_re", mem_re, 0);
        chk("mid_rst_dump_d", dump_d, 0);
        chk("mid_rst_valid", dump_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        r = '{5, 1, 0, 0, 0, 1, 1, 4};
        run_dump(r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-002 SHALL have parameter AW, default 9, giving the word-address width.
REQ-003 SHALL have parameter DW, default 32, giving the data width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 abort  in  1  terminates an active dump.
REQ-008 base_a  in  AW  first word address of the dump.
REQ-009 count  in  AW+1  number of words to dump, 0..512.
REQ-010 mem_a  out  AW  read address to the instruction/data memory.
REQ-011 mem_re  out  1  read strobe; the memory returns mem_q one cycle later.
REQ-012 mem_q  in  DW  memory read data.
REQ-013 dump_d  out  DW  word being dumped.
REQ-014 dump_valid  out  1  dump_d is valid.
REQ-015 dump_ready  in  1  the consumer accepts dump_d.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse when a dump ends, whether completed or aborted.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WAIT, SEND, FIN; every output SHALL be registered.
REQ-019 IDLE with start=1 and count!=0: latch base_a into addr and count into rem, then go to READ.
REQ-020 IDLE with start=1 and count==0: go to FIN; no mem_re is issued.
REQ-021 READ SHALL assert mem_re=1 with mem_a=addr for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL capture mem_q into dump_d at the end of the cycle, then go to SEND.
REQ-023 SEND SHALL hold dump_valid=1 and keep dump_d stable until dump_ready=1.
REQ-024 On a SEND handshake: rem decrements; if rem becomes 0, go to FIN; otherwise addr increments and the FSM goes to READ.
REQ-025 addr SHALL wrap from 2^AW-1 to 0 with no error indication.
REQ-026 FIN SHALL assert done=1 for one cycle, then go to IDLE.
REQ-027 Latency: start sampled in cycle T gives mem_re in T+1 and the first dump_valid in T+3.
REQ-028 With dump_ready held at 1, throughput SHALL be one word per 3 cycles.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 abort=1 in any non-IDLE state SHALL go to FIN on the next edge, and dump_valid SHALL drop in that edge's cycle.
REQ-031 An abort in the same cycle as a SEND handshake SHALL count the word as delivered, then go to FIN.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 mem_re SHALL never be asserted outside READ.

Reset
REQ-034 rst=1 SHALL force state=IDLE and set mem_a, mem_re, dump_d, dump_valid, busy, done, addr and rem all to 0.
REQ-035 rst SHALL take priority over start and abort, and SHALL abandon any dump in progress without a done pulse.

Structure
REQ-036 The FSM state enumeration, AW and DW SHALL live in the shared processor package with the memory address/data widths.
REQ-037 There SHALL be no sub-module; the address/remaining counter pair SHALL stay inline.

Verification
REQ-038 Scenario: memory preloaded mem[0..5]=0x11111111..0x66666666; base_a=0, count=6, dump_ready=1 -> six words in order, each 3 cycles apart; done pulses once; busy falls with done.
REQ-039 Scenario: base_a=510, count=4 -> mem_a sequence 510, 511, 0, 1; dump_d returns the contents of those addresses.
REQ-040 Scenario: count=2, dump_ready low for 5 cycles in the first SEND -> dump_d stable, dump_valid=1 throughout, no extra mem_re, two words total.
REQ-041 Scenario: count=0 -> done pulse 1 cycle after start; mem_re and dump_valid never asserted.
REQ-042 Scenario: count=6, abort in the second WAIT -> exactly one word delivered, done pulses, FSM returns to IDLE.
REQ-043 Scenario: rst during SEND of word 3 -> all outputs 0 next cycle, no done; a following start with base_a=5, count=1 delivers mem[5].
